sdram_read_scheduler: RTL and testbench
=======================================

Name: sdram_read_scheduler

Overview:
- Sequences burst reads from the SDRAM controller into the 512x32 read FIFO.
- Shares that single read path between NR_OF_REQ requesters using round-robin arbitration.
- Issues a burst only when the FIFO has guaranteed space for it, tracked as credits, so the FIFO never overflows.
- Drives the FIFO push and clear controls; sits between the requesters (I-cache, D-cache, DMA) and the SDRAM controller.

Parameters:
- NR_OF_REQ, 4, number of requesters (2..8).
- FIFO_DEPTH, 512, read FIFO capacity in words; the credit counter is clog2(FIFO_DEPTH)+1 bits wide.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- request  in  NR_OF_REQ  per-requester burst-read request, level, held until done.
- requestAddress  in  NR_OF_REQ*24  flattened word addresses; slice i belongs to requester i.
- requestBurstLength  in  NR_OF_REQ*8  flattened; value n means a burst of n+1 words (1..256).
- grant  out  NR_OF_REQ  one-hot, the requester currently being served.
- done  out  1  one-cycle pulse when the granted burst has fully arrived in the FIFO.
- sdramReadRequest  out  1  read command to the SDRAM controller.
- sdramAddress  out  24  burst start address.
- sdramBurstLength  out  8  burst length, n+1 encoding.
- sdramAck  in  1  controller accepted the command.
- sdramDataValid  in  1  one returned data word this cycle.
- sdramData  in  32  returned data word.
- fifoPush  out  1  FIFO push, equal to sdramDataValid in RECEIVE.
- fifoDataIn  out  32  equal to sdramData.
- fifoPopped  in  1  consumer popped one word (qualified pop: pop and not empty).
- clearReadFifo  out  1  one-cycle FIFO clear.
- abort  in  1  abandon the current burst.

Behaviour:
- Reset values:
  - state IDLE; grant 0; done 0; sdramReadRequest 0; clearReadFifo 0.
  - credits = FIFO_DEPTH; rrPointer = NR_OF_REQ-1, so requester 0 has first priority.
- State IDLE:
  - Search the requesters starting at rrPointer+1, wrapping modulo NR_OF_REQ.
  - Take the first requester i with request[i]=1 and credits >= burst(i)+1.
  - If found: latch i, its address and its length; set grant to one-hot i; go to ISSUE the next cycle.
  - A requester short of credits is skipped this cycle, not blocked. Others may be chosen.
- State ISSUE:
  - sdramReadRequest=1, with sdramAddress and sdramBurstLength taken from the latched values.
  - On sdramAck: credits -= burst+1; wordCount = burst+1; go to RECEIVE.
  - Request-to-grant latency is 1 cycle; grant-to-command latency is 0 cycles.
- State RECEIVE:
  - Each sdramDataValid asserts fifoPush for the same cycle (combinational) and decrements wordCount.
  - When the last word is pushed, go to DONE.
- State DONE:
  - done=1 for one cycle; grant is still valid during this cycle.
  - rrPointer = i; next state IDLE, and grant clears.
- Credits:
  - fifoPopped adds 1 each cycle it is high.
  - On the sdramAck cycle, the burst subtraction and a pop increment combine in the same cycle.
  - Credits saturate at FIFO_DEPTH and can never go negative; a decrement is only issued when credits are sufficient.
- Abort in ISSUE or RECEIVE:
  - clearReadFifo=1 for one cycle; credits reset to FIFO_DEPTH.
  - sdramReadRequest drops; grant clears; no done pulse.
  - Go to IDLE; rrPointer = i, so the aborted requester loses priority.
  - Data words arriving after an abort are not pushed. The SDRAM controller guarantees it stops bursts when sdramReadRequest is withdrawn before ack.
  - Abort in IDLE or DONE is ignored.
- Reset mid-burst: immediate return to reset values, with no clear pulse; the FIFO is reset by the same reset.
- A requester that drops request while granted is still served to completion.
- sdramDataValid outside RECEIVE is ignored: no push.

Optional Feature:
- SDRAM_SCHED_TIMEOUT_EN defined:
  - A 10-bit watchdog counts cycles in ISSUE or RECEIVE without sdramAck or sdramDataValid.
  - At 1023 the block behaves as an abort and sets the sticky output timeoutError.
  - timeoutError clears only on reset.
- Undefined:
  - No watchdog, and no timeoutError port.
  - A stalled SDRAM controller hangs the scheduler in ISSUE or RECEIVE indefinitely.

Test Plan:
- Single burst: request[0]=1, length=7, address 0x000100; ack after 3 cycles; 8 valid words -> 8 fifoPush pulses, done once, credits 504, then 512 after 8 pops.
- Round-robin: request[0] and request[2] both held with length 0 -> grant order 0,2,0,2; after adding request[1] -> 0,1,2,0.
- Credit stall: fill so credits=100, request[1] length=199 -> never granted; after 100 fifoPopped pulses (credits 200) -> granted the next IDLE cycle.
- Abort mid-RECEIVE after 5 of 16 words -> clearReadFifo 1 cycle, no done, credits 512, later valid words not pushed.
- Simultaneous sdramAck and fifoPopped with credits 512, length 255 -> credits 257 the next cycle.
- Reset asserted in RECEIVE -> next cycle grant=0, sdramReadRequest=0, credits=512, requester 0 first priority afterwards.

Source files
------------

// File: rtl/sdram_read_scheduler.sv
// sdram_read_scheduler
// Round-robin scheduler that shares the single SDRAM burst-read path between
// NR_OF_REQ requesters. It fills the 512x32 read FIFO and tracks free FIFO
// space as credits, so a burst is only issued when it is certain to fit.
//
// Optional build macro: SDRAM_SCHED_TIMEOUT_EN
//   defined   -> 10-bit watchdog on ISSUE/RECEIVE. A stall of 1023 cycles acts
//                as an abort and sets the sticky timeoutError output.
//   undefined -> no watchdog and no timeoutError port.
//
// Handshake: sdramReadRequest is held, with stable sdramAddress and
// sdramBurstLength, until the cycle in which sdramAck is also high; that cycle
// transfers the command. Returned data has no back-pressure: every cycle with
// sdramDataValid in RECEIVE is one word pushed into the FIFO.
module sdram_read_scheduler #(
  parameter int NR_OF_REQ  = 4,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NR_OF_REQ-1:0]          request,
  input  logic [NR_OF_REQ*24-1:0]       requestAddress,
  input  logic [NR_OF_REQ*8-1:0]        requestBurstLength,
  output logic [NR_OF_REQ-1:0]          grant,
  output logic                          done,
  output logic                          sdramReadRequest,
  output logic [23:0]                   sdramAddress,
  output logic [7:0]                    sdramBurstLength,
  input  logic                          sdramAck,
  input  logic                          sdramDataValid,
  input  logic [31:0]                   sdramData,
  output logic                          fifoPush,
  output logic [31:0]                   fifoDataIn,
  input  logic                          fifoPopped,
  output logic                          clearReadFifo,
  input  logic                          abort,
`ifdef SDRAM_SCHED_TIMEOUT_EN
  output logic                          timeoutError,
`endif
  output logic [1:0]                    debugState,
  output logic [$clog2(FIFO_DEPTH):0]   debugCredits
);

  localparam int PTR_W = $clog2(NR_OF_REQ);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  // Arithmetic width wide enough for credits, a full 256-word burst and a pop.
  localparam int AW    = ((CW > 9) ? CW : 9) + 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RECEIVE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    credits;
  logic [CW-1:0]    creditNext;
  logic [AW-1:0]    creditSum;
  logic [PTR_W-1:0] rrPointer;
  logic [PTR_W-1:0] servedIndex;
  logic [23:0]      latchedAddress;
  logic [7:0]       latchedLength;
  logic [8:0]       wordCount;

  logic [7:0]       lenArray  [NR_OF_REQ];
  logic [23:0]      addrArray [NR_OF_REQ];

  logic             pickValid;
  logic [PTR_W-1:0] pickIndex;
  logic [PTR_W:0]   candidate;

  logic             inBurst;
  logic             abortEvent;
  logic             watchdogExpired;

  for (genvar g = 0; g < NR_OF_REQ; g++) begin : gSlices
    assign lenArray[g]  = requestBurstLength[g*8 +: 8];
    assign addrArray[g] = requestAddress[g*24 +: 24];
  end

  assign inBurst    = (state == S_ISSUE) || (state == S_RECEIVE);
  // Reset wins over abort so a reset mid-burst never produces a clear pulse.
  assign abortEvent = !reset && inBurst && (abort || watchdogExpired);

  assign sdramReadRequest = (state == S_ISSUE) && !abortEvent;
  assign sdramAddress     = latchedAddress;
  assign sdramBurstLength = latchedLength;
  assign fifoPush         = (state == S_RECEIVE) && sdramDataValid && !abortEvent;
  assign fifoDataIn       = sdramData;
  assign clearReadFifo    = abortEvent;
  assign done             = (state == S_DONE);
  assign debugState       = state;
  assign debugCredits     = credits;

  // Round-robin search from rrPointer+1; requesters short of credits are skipped.
  always_comb begin
    pickValid = 1'b0;
    pickIndex = '0;
    candidate = '0;
    for (int k = 1; k <= NR_OF_REQ; k++) begin
      candidate = {1'b0, rrPointer} + (PTR_W+1)'(k);
      if (candidate >= (PTR_W+1)'(NR_OF_REQ)) begin
        candidate = candidate - (PTR_W+1)'(NR_OF_REQ);
      end
      if (!pickValid && request[candidate[PTR_W-1:0]] &&
          (AW'(credits) >= AW'(lenArray[candidate[PTR_W-1:0]]) + AW'(1))) begin
        pickValid = 1'b1;
        pickIndex = candidate[PTR_W-1:0];
      end
    end
  end

  // Next credit value: pop adds one, an accepted command reserves its burst.
  always_comb begin
    creditSum = AW'(credits) + AW'(fifoPopped);
    if ((state == S_ISSUE) && sdramAck) begin
      creditSum = creditSum - (AW'(latchedLength) + AW'(1));
    end
    if (creditSum > AW'(FIFO_DEPTH)) begin
      creditNext = CW'(FIFO_DEPTH);
    end else begin
      creditNext = creditSum[CW-1:0];
    end
  end

  // Main sequencer: arbitration, command issue, data receive, completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      grant          <= '0;
      credits        <= CW'(FIFO_DEPTH);
      rrPointer      <= PTR_W'(NR_OF_REQ - 1);
      servedIndex    <= '0;
      latchedAddress <= '0;
      latchedLength  <= '0;
      wordCount      <= '0;
    end else if (abortEvent) begin
      state     <= S_IDLE;
      grant     <= '0;
      credits   <= CW'(FIFO_DEPTH);
      rrPointer <= servedIndex;
      wordCount <= '0;
    end else begin
      credits <= creditNext;
      case (state)
        S_IDLE: begin
          if (pickValid) begin
            servedIndex    <= pickIndex;
            latchedAddress <= addrArray[pickIndex];
            latchedLength  <= lenArray[pickIndex];
            grant          <= NR_OF_REQ'(1) << pickIndex;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sdramAck) begin
            wordCount <= {1'b0, latchedLength} + 9'd1;
            state     <= S_RECEIVE;
          end
        end
        S_RECEIVE: begin
          if (sdramDataValid) begin
            wordCount <= wordCount - 9'd1;
            if (wordCount == 9'd1) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          rrPointer <= servedIndex;
          grant     <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SDRAM_SCHED_TIMEOUT_EN
  logic [9:0] watchdog;

  assign watchdogExpired = (watchdog == 10'd1023);

  // Watchdog counts silent cycles inside a burst; timeoutError is sticky.
  always_ff @(posedge clock) begin
    if (reset) begin
      watchdog     <= '0;
      timeoutError <= 1'b0;
    end else begin
      if (inBurst && watchdogExpired) begin
        timeoutError <= 1'b1;
      end
      if (!inBurst || abortEvent || sdramAck || sdramDataValid) begin
        watchdog <= '0;
      end else begin
        watchdog <= watchdog + 10'd1;
      end
    end
  end
`else
  assign watchdogExpired = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_read_scheduler.sv
// Bench for sdram_read_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the scheduler.
module tb_sdram_read_scheduler;

  localparam int N     = 4;
  localparam int DEPTH = 512;

  // ---------------- clock / reset / DUT ----------------
  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    request;
  logic [N*24-1:0] requestAddress;
  logic [N*8-1:0]  requestBurstLength;
  logic [N-1:0]    grant;
  logic            done;
  logic            sdramReadRequest;
  logic [23:0]     sdramAddress;
  logic [7:0]      sdramBurstLength;
  logic            sdramAck;
  logic            sdramDataValid;
  logic [31:0]     sdramData;
  logic            fifoPush;
  logic [31:0]     fifoDataIn;
  logic            fifoPopped;
  logic            clearReadFifo;
  logic            abort;
`ifdef SDRAM_SCHED_TIMEOUT_EN
  logic            timeoutError;
`endif
  logic [1:0]      debugState;
  logic [9:0]      debugCredits;

  always #5 clock = ~clock;

  sdram_read_scheduler #(.NR_OF_REQ(N), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .request(request),
    .requestAddress(requestAddress), .requestBurstLength(requestBurstLength),
    .grant(grant), .done(done), .sdramReadRequest(sdramReadRequest),
    .sdramAddress(sdramAddress), .sdramBurstLength(sdramBurstLength),
    .sdramAck(sdramAck), .sdramDataValid(sdramDataValid), .sdramData(sdramData),
    .fifoPush(fifoPush), .fifoDataIn(fifoDataIn), .fifoPopped(fifoPopped),
    .clearReadFifo(clearReadFifo), .abort(abort),
`ifdef SDRAM_SCHED_TIMEOUT_EN
    .timeoutError(timeoutError),
`endif
    .debugState(debugState), .debugCredits(debugCredits)
  );

  // ---------------- bookkeeping ----------------
  int nChecks = 0;
  int nPass   = 0;
  int pushCnt = 0;
  int doneCnt = 0;
  int clearCnt = 0;
  int grantLog[$];
  logic [N-1:0] prevGrant = '0;

  bit autoDrop = 1'b1;
  bit popEn    = 1'b1;
  int abortRate = 0;

  // ---------------- reference model ----------------
  // Transaction view: which requester is served (-1 none), whether its
  // command is still outstanding, how many words are still owed, and
  // whether the completion cycle is due.
  int          mCredits;
  int          mRr;
  int          mServ;
  bit          mCmd;
  int          mLeft;
  bit          mDone;
  logic [23:0] mAddr;
  int          mLen;
  int          mOcc;

  function automatic int lenOf(input int i);
    return int'(requestBurstLength[i*8 +: 8]);
  endfunction

  task automatic model_reset();
    mCredits = DEPTH; mRr = N - 1; mServ = -1; mCmd = 0;
    mLeft = 0; mDone = 0; mAddr = '0; mLen = 0; mOcc = 0;
  endtask

  task automatic model_update(input bit abortEff);
    int c;
    bit push;
    bit found;
    int idx;
    if (reset) begin
      model_reset();
      return;
    end
    push = (mLeft > 0) && sdramDataValid && !abortEff;
    if (abortEff) begin
      mCredits = DEPTH; mRr = mServ; mServ = -1; mCmd = 0; mLeft = 0; mOcc = 0;
      return;
    end
    c = mCredits;
    if (mDone) begin
      mRr = mServ; mServ = -1; mDone = 0;
    end else if (mCmd) begin
      if (sdramAck) begin
        mCmd = 0; mLeft = mLen + 1; c = c - (mLen + 1);
      end
    end else if (mLeft > 0) begin
      if (sdramDataValid) begin
        mLeft = mLeft - 1;
        if (mLeft == 0) mDone = 1;
      end
    end else begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (mRr + k) % N;
        if (!found && request[idx] && mCredits >= lenOf(idx) + 1) begin
          found = 1; mServ = idx; mCmd = 1;
          mAddr = requestAddress[idx*24 +: 24]; mLen = lenOf(idx);
        end
      end
    end
    c = c + int'(fifoPopped);
    if (c > DEPTH) c = DEPTH;
    mCredits = c;
    if (push) mOcc = mOcc + 1;
    if (fifoPopped && mOcc > 0) mOcc = mOcc - 1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: compare outputs against the model, advance the model.
  task automatic tick();
    bit abortEff;
    logic [N-1:0] expGrant;
    #1;
    abortEff = !reset && abort && (mCmd || mLeft > 0);
    expGrant = (mServ >= 0) ? (N'(1) << mServ) : '0;
    check("grant", 32'(grant), 32'(expGrant));
    check("done", 32'(done), 32'(mDone));
    check("sdramReadRequest", 32'(sdramReadRequest), 32'(mCmd && !abortEff));
    if (mCmd) begin
      check("sdramAddress", 32'(sdramAddress), 32'(mAddr));
      check("sdramBurstLength", 32'(sdramBurstLength), 32'(mLen));
    end
    check("fifoPush", 32'(fifoPush), 32'((mLeft > 0) && sdramDataValid && !abortEff));
    check("fifoDataIn", fifoDataIn, sdramData);
    check("clearReadFifo", 32'(clearReadFifo), 32'(abortEff));
    check("credits", 32'(debugCredits), 32'(mCredits));
    pushCnt  += int'(fifoPush);
    doneCnt  += int'(done);
    clearCnt += int'(clearReadFifo);
    if (grant != '0 && prevGrant == '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) grantLog.push_back(i);
    end
    prevGrant = grant;
    @(posedge clock);
    model_update(abortEff);
    @(negedge clock);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; request = '0; sdramAck = 0; sdramDataValid = 0;
    fifoPopped = 0; abort = 0; sdramData = '0;
    repeat (2) @(posedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    prevGrant = '0;
  endtask

  // Behaves like a cooperating controller and consumer.
  task automatic drive_auto();
    if (autoDrop && mServ >= 0) request[mServ] = 1'b0;
    sdramAck       = mCmd && ($urandom_range(0, 2) == 0);
    sdramDataValid = ($urandom_range(0, 1) == 0);
    sdramData      = $urandom;
    fifoPopped     = popEn && (mOcc > 0) && ($urandom_range(0, 1) == 0);
    abort          = (abortRate > 0) && ($urandom_range(0, abortRate - 1) == 0);
  endtask

  task automatic quiet();
    sdramAck = 0; sdramDataValid = 0; fifoPopped = 0; abort = 0;
  endtask

  task automatic run_until(input int gTarget, input int dTarget, input int maxCycles,
                           input string name);
    int n;
    n = 0;
    while ((grantLog.size() < gTarget || doneCnt < dTarget) && n < maxCycles) begin
      drive_auto();
      tick();
      n++;
    end
    quiet();
    nChecks++;
    if (n >= maxCycles) $display("FAIL %s_wait: still waiting after %0d cycles, expected completion", name, n);
    else nPass++;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p0, d0, c0, g0;
    int expRr[8];
    expRr = '{0, 2, 0, 2, 0, 1, 2, 0};
    requestAddress = '0; requestBurstLength = '0;
    model_reset();
    do_reset();

    // Reset state
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_sdramReadRequest", 32'(sdramReadRequest), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_clear", 32'(clearReadFifo), 32'h0);
    check("reset_credits", 32'(debugCredits), 32'd512);

    // Single burst: 8 words from 0x000100
    requestAddress[0 +: 24] = 24'h000100;
    requestBurstLength[0 +: 8] = 8'd7;
    request = 4'b0001;
    tick();
    check("single_grant", 32'(grant), 32'h1);
    check("single_cmd", 32'(sdramReadRequest), 32'h1);
    check("single_addr", 32'(sdramAddress), 32'h000100);
    check("single_len", 32'(sdramBurstLength), 32'd7);
    request = '0;
    tick(); tick();
    sdramAck = 1; tick(); sdramAck = 0;
    check("single_credits_after_ack", 32'(debugCredits), 32'd504);
    p0 = pushCnt; d0 = doneCnt;
    for (int w = 0; w < 8; w++) begin
      sdramDataValid = 1; sdramData = $urandom; tick();
      sdramDataValid = 0; tick();
    end
    tick();
    check("single_pushes", 32'(pushCnt - p0), 32'd8);
    check("single_done_pulses", 32'(doneCnt - d0), 32'd1);
    check("single_credits_before_pop", 32'(debugCredits), 32'd504);
    fifoPopped = 1; repeat (8) tick(); fifoPopped = 0; tick();
    check("single_credits_after_pop", 32'(debugCredits), 32'd512);

    // Round-robin order
    do_reset();
    grantLog.delete();
    requestBurstLength = '0;
    autoDrop = 0; popEn = 1;
    request = 4'b0101;
    run_until(4, 0, 300, "rr_first");
    request = 4'b0111;
    run_until(8, 0, 400, "rr_second");
    request = '0;
    repeat (30) begin drive_auto(); tick(); end
    quiet();
    check("rr_grant_count", 32'(grantLog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < grantLog.size()) check($sformatf("rr_order_%0d", i), 32'(grantLog[i]), 32'(expRr[i]));
    end

    // Credit stall
    do_reset();
    autoDrop = 1; popEn = 0;
    requestBurstLength[0 +: 8] = 8'd255; request = 4'b0001;
    run_until(grantLog.size() + 1, doneCnt + 1, 2000, "stall_fill_a");
    requestBurstLength[0 +: 8] = 8'd155; request = 4'b0001;
    run_until(grantLog.size() + 1, doneCnt + 1, 2000, "stall_fill_b");
    check("stall_credits_100", 32'(debugCredits), 32'd100);
    requestBurstLength[8 +: 8] = 8'd199; request = 4'b0010;
    repeat (20) tick();
    check("stall_no_grant", 32'(grant), 32'h0);
    fifoPopped = 1; repeat (99) tick();
    check("stall_credits_199", 32'(debugCredits), 32'd199);
    check("stall_no_grant_199", 32'(grant), 32'h0);
    tick(); fifoPopped = 0;
    check("stall_credits_200", 32'(debugCredits), 32'd200);
    check("stall_no_grant_yet", 32'(grant), 32'h0);
    tick();
    check("stall_granted", 32'(grant), 32'h2);
    popEn = 1;
    run_until(0, doneCnt + 1, 2000, "stall_drain");

    // Abort mid-RECEIVE after 5 of 16 words
    do_reset();
    popEn = 0;
    requestBurstLength[0 +: 8] = 8'd15; requestAddress[0 +: 24] = 24'($urandom);
    request = 4'b0001; tick();
    request = '0; sdramAck = 1; tick(); sdramAck = 0;
    p0 = pushCnt; d0 = doneCnt; c0 = clearCnt;
    sdramDataValid = 1; repeat (5) tick();
    abort = 1; tick(); abort = 0;
    repeat (3) tick();
    sdramDataValid = 0; repeat (3) tick();
    check("abort_pushes", 32'(pushCnt - p0), 32'd5);
    check("abort_clear_pulses", 32'(clearCnt - c0), 32'd1);
    check("abort_no_done", 32'(doneCnt - d0), 32'd0);
    check("abort_credits", 32'(debugCredits), 32'd512);
    check("abort_grant", 32'(grant), 32'h0);

    // Simultaneous ack and pop
    do_reset();
    requestBurstLength[0 +: 8] = 8'd255; request = 4'b0001; tick();
    request = '0; sdramAck = 1; fifoPopped = 1; tick();
    sdramAck = 0; fifoPopped = 0;
    check("ackpop_credits", 32'(debugCredits), 32'd257);
    popEn = 1;
    run_until(0, doneCnt + 1, 2000, "ackpop_drain");

    // Reset during RECEIVE
    do_reset();
    autoDrop = 1;
    requestBurstLength[0 +: 8] = 8'd3; requestBurstLength[8 +: 8] = 8'd15;
    request = 4'b0001;
    run_until(grantLog.size() + 1, doneCnt + 1, 500, "rst_prep");
    request = 4'b0010; tick();
    sdramAck = 1; tick(); sdramAck = 0;
    sdramDataValid = 1; repeat (3) tick(); sdramDataValid = 0;
    reset = 1; tick(); reset = 0;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_cmd", 32'(sdramReadRequest), 32'h0);
    check("rst_credits", 32'(debugCredits), 32'd512);
    request = 4'b0011; tick();
    check("rst_priority_req0", 32'(grant), 32'h1);
    g0 = grantLog.size();
    run_until(g0 + 1, doneCnt + 2, 1000, "rst_drain");

    // Randomized traffic with occasional aborts
    do_reset();
    autoDrop = 1; popEn = 1; abortRate = 150;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!request[i] && $urandom_range(0, 5) == 0) begin
          requestAddress[i*24 +: 24] = 24'($urandom);
          requestBurstLength[i*8 +: 8] = ($urandom_range(0, 9) == 0) ?
            8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
          request[i] = 1'b1;
        end
      end
      drive_auto();
      tick();
    end
    abortRate = 0; request = '0;
    repeat (800) begin drive_auto(); tick(); end
    quiet();
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
